decoder_seq_scan: RTL and testbench
===================================

// Module: decoder_seq_scan
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder with a built-in sequential scan engine.
//  DIRECT use: registered one-hot strobe from a SEL_W-bit index (e.g. register-file write enables).
//  SCAN use: walks every output in turn, e.g. to clear/initialise all registers after reset.
//  Sits between control logic and any bank of 2**SEL_W enable-gated elements.
// PARAMETERS
//  SEL_W       3   select width; OUT_W = 2**SEL_W outputs (localparam); legal 1..6
//  SCAN_DWELL  1   cycles each output is held high during a scan; legal 1..255
// PORTS
//  clk     in   1        rising-edge clock
//  reset   in   1        asynchronous, active-high reset
//  en      in   1        DIRECT: output enable; SCAN: 0 stalls the scan (no advance)
//  sel     in   SEL_W    DIRECT-mode index
//  start   in   1        pulse; begins a scan when state is IDLE
//  abort   in   1        terminates an active scan
//  out     out  OUT_W    registered one-hot (or all-zero) output
//  idx     out  SEL_W    index currently driven (DIRECT: last sel; SCAN: scan pointer)
//  busy    out  1        high in SCAN
//  done    out  1        one-cycle pulse after a scan completes normally
// BEHAVIOUR
//  Reset (async, any time incl. mid-scan): state=IDLE, out=0, idx=0, busy=0, done=0, dwell cnt=0.
//  States: IDLE, SCAN, DONE. All outputs registered; latency input->out = 1 cycle.
//  IDLE:
//   - start=1: next cycle state=SCAN, idx=0, out=1<<0, busy=1, dwell cnt=0. start has priority over en.
//   - else en=1: next cycle out=1<<sel, idx=sel. en=0: out=0, idx holds.
//   - abort in IDLE ignored.
//  SCAN:
//   - abort=1 (highest priority): next cycle state=IDLE, out=0, busy=0, done=0; idx holds.
//   - en=0: full stall; out, idx, dwell cnt hold.
//   - en=1 and cnt<SCAN_DWELL-1: cnt++.
//   - en=1 and cnt==SCAN_DWELL-1 and idx<OUT_W-1: idx++, out=1<<(idx+1), cnt=0.
//   - en=1 and cnt==SCAN_DWELL-1 and idx==OUT_W-1: state=DONE, out=0, busy=0, done=1.
//   - start ignored while busy; sel ignored.
//  DONE: lasts exactly 1 cycle; done=1, out=0. Next cycle IDLE, done=0.
//   start/en in DONE ignored (no new scan or decode until IDLE).
//  Scan length with en=1 throughout: OUT_W*SCAN_DWELL cycles of busy, then 1 done cycle.
//  out is never multi-hot; idx does not wrap (scan ends at OUT_W-1).
//  dwell counter width = clog2(SCAN_DWELL+1); for SCAN_DWELL=1 counter is constant 0.
//  No X propagation: out=0 whenever state != IDLE/SCAN-active-decode.
// TESTING
//  1 Reset: assert reset mid-cycle -> out=8'h00, idx=0, busy=0, done=0 immediately (async).
//  2 DIRECT (SEL_W=3): en=1, sel=5 -> next cycle out=8'h20, idx=5; en=0 -> out=8'h00, idx=5.
//  3 SCAN (DWELL=1): start pulse -> out 8'h01,02,04..80 on 8 consecutive cycles, busy=1,
//    then done=1 out=0 for 1 cycle, then IDLE.
//  4 SCAN DWELL=3, en low for 2 cycles at idx=2 -> 8'h04 held 5 cycles total; total busy=26.
//  5 Abort at idx=4 with start also high -> next cycle out=0, busy=0, done never pulses;
//    new start next IDLE cycle restarts at 8'h01.
//  6 start=1 and en=1, sel=7 same IDLE cycle -> scan wins, out=8'h01 not 8'h80;
//    reset asserted at idx=6 -> out=0 immediately, state IDLE.

Source files
------------

// File: rtl/decoder_seq_scan.sv
// Registered binary-to-one-hot decoder with a sequential scan engine that walks
// every output in turn, holding each for SCAN_DWELL enabled cycles.
module decoder_seq_scan #(
  parameter int SEL_W      = 3,
  parameter int SCAN_DWELL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                start,
  input  logic                abort,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                busy,
  output logic                done
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = $clog2(SCAN_DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nx;
  logic [OUT_W-1:0] out_nx;
  logic [SEL_W-1:0] idx_nx, idx_inc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy_nx, done_nx;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      out   <= out_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    out_nx   = out;
    idx_nx   = idx;
    cnt_nx   = cnt;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx  = '0;
        busy_nx = 1'b0;
        if (start) begin
          state_nx = SCAN;
          idx_nx   = '0;
          out_nx   = onehot('0);
          busy_nx  = 1'b1;
        end else if (en) begin
          out_nx = onehot(sel);
          idx_nx = sel;
        end else begin
          out_nx = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nx = IDLE;
          out_nx   = '0;
          busy_nx  = 1'b0;
          cnt_nx   = '0;
        end else if (en) begin
          if (cnt != CNT_MAX) begin
            cnt_nx = cnt + 1'b1;
          end else if (idx != IDX_MAX) begin
            idx_nx = idx_inc;
            out_nx = onehot(idx_inc);
            cnt_nx = '0;
          end else begin
            // last output finished its dwell: end the scan with a done pulse
            state_nx = DONE;
            out_nx   = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            cnt_nx   = '0;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        out_nx   = '0;
        busy_nx  = 1'b0;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        out_nx   = '0;
        busy_nx  = 1'b0;
        cnt_nx   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_decoder_seq_scan.sv
// Directed bench: instance a (SEL_W=3, DWELL=1) and instance b (SEL_W=3, DWELL=3).
module tb_decoder_seq_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_en = 0, a_start = 0, a_abort = 0;
  logic [2:0] a_sel = '0;
  logic [7:0] a_out;
  logic [2:0] a_idx;
  logic       a_busy, a_done;
  logic       b_en = 0, b_start = 0, b_abort = 0;
  logic [2:0] b_sel = '0;
  logic [7:0] b_out;
  logic [2:0] b_idx;
  logic       b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_seq_scan #(.SEL_W(3), .SCAN_DWELL(1)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .sel(a_sel), .start(a_start), .abort(a_abort),
    .out(a_out), .idx(a_idx), .busy(a_busy), .done(a_done));

  decoder_seq_scan #(.SEL_W(3), .SCAN_DWELL(3)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .sel(b_sel), .start(b_start), .abort(b_abort),
    .out(b_out), .idx(b_idx), .busy(b_busy), .done(b_done));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if ({a_out, a_idx, a_busy, a_done} !== 13'h0) begin n_fail++; $display("FAIL reset_init out=%h idx=%0d busy=%b done=%b want 0", a_out, a_idx, a_busy, a_done); end
    n_checks++; if ({b_out, b_idx, b_busy, b_done} !== 13'h0) begin n_fail++; $display("FAIL reset_init_b out=%h idx=%0d want 0", b_out, b_idx); end
    reset = 1'b0;
    a_en = 1; a_sel = 3'd5; step();
    n_checks++; if (a_out !== 8'h20) begin n_fail++; $display("FAIL pre_reset out=%h want 20", a_out); end
    #2 reset = 1'b1; #1;
    n_checks++; if ({a_out, a_idx, a_busy, a_done} !== 13'h0) begin n_fail++; $display("FAIL reset_async out=%h idx=%0d busy=%b done=%b want 0", a_out, a_idx, a_busy, a_done); end
    a_en = 0; #1 reset = 1'b0;
  endtask

  task automatic test_direct();
    a_en = 1; a_sel = 3'd5; step();
    n_checks++; if (a_out !== 8'h20 || a_idx !== 3'd5) begin n_fail++; $display("FAIL direct_sel5 out=%h idx=%0d want 20/5", a_out, a_idx); end
    a_en = 0; step();
    n_checks++; if (a_out !== 8'h00 || a_idx !== 3'd5) begin n_fail++; $display("FAIL direct_en0 out=%h idx=%0d want 00/5", a_out, a_idx); end
    a_en = 1; a_sel = 3'd0; step();
    n_checks++; if (a_out !== 8'h01 || a_idx !== 3'd0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL direct_sel0 out=%h idx=%0d busy=%b want 01/0/0", a_out, a_idx, a_busy); end
    a_en = 0; step();
  endtask

  task automatic test_scan_dwell1();
    logic [7:0] exp;
    a_en = 1; a_start = 1; step(); a_start = 0;
    exp = 8'h01;
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (a_out !== exp || a_idx !== 3'(k) || a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL scan1_step%0d out=%h idx=%0d busy=%b done=%b want %h/%0d/1/0", k, a_out, a_idx, a_busy, a_done, exp, k); end
      exp = exp << 1;
      step();
    end
    n_checks++; if (a_done !== 1'b1 || a_out !== 8'h00 || a_busy !== 1'b0) begin n_fail++; $display("FAIL scan1_done done=%b out=%h busy=%b want 1/00/0", a_done, a_out, a_busy); end
    a_start = 1; a_sel = 3'd3; step(); a_start = 0;
    n_checks++; if (a_done !== 1'b0 || a_out !== 8'h00 || a_busy !== 1'b0) begin n_fail++; $display("FAIL done_ignores done=%b out=%h busy=%b want 0/00/0", a_done, a_out, a_busy); end
    step();
    n_checks++; if (a_out !== 8'h08 || a_idx !== 3'd3 || a_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_done out=%h idx=%0d busy=%b want 08/3/0", a_out, a_idx, a_busy); end
    a_en = 0; step();
  endtask

  task automatic test_dwell3_stall();
    int busy_cnt = 0, cnt04 = 0, done_cnt = 0, done_t = -1, multi = 0;
    logic [7:0] out_t25 = '0;
    b_en = 1; b_start = 1; step(); b_start = 0;
    for (int t = 0; t < 40; t++) begin
      b_en = !(t == 7 || t == 8);
      if (b_busy) busy_cnt++;
      if (b_out == 8'h04) cnt04++;
      if (b_done) begin done_cnt++; done_t = t; end
      if ((b_out & (b_out - 8'd1)) != 8'h00) multi++;
      if (t == 25) out_t25 = b_out;
      step();
    end
    n_checks++; if (busy_cnt != 26) begin n_fail++; $display("FAIL dwell3_busy got=%0d want 26", busy_cnt); end
    n_checks++; if (cnt04 != 5) begin n_fail++; $display("FAIL dwell3_hold04 got=%0d want 5", cnt04); end
    n_checks++; if (done_cnt != 1 || done_t != 26) begin n_fail++; $display("FAIL dwell3_done count=%0d at=%0d want 1 at 26", done_cnt, done_t); end
    n_checks++; if (multi != 0) begin n_fail++; $display("FAIL dwell3_onehot multihot_cycles=%0d want 0", multi); end
    n_checks++; if (out_t25 !== 8'h80) begin n_fail++; $display("FAIL dwell3_last out=%h want 80", out_t25); end
    b_en = 0; step();
  endtask

  task automatic test_abort();
    int done_seen = 0;
    a_en = 1; a_start = 1; step(); a_start = 0;
    for (int k = 0; k < 4; k++) begin if (a_done) done_seen++; step(); end
    n_checks++; if (a_idx !== 3'd4 || a_out !== 8'h10) begin n_fail++; $display("FAIL abort_pre idx=%0d out=%h want 4/10", a_idx, a_out); end
    a_abort = 1; a_start = 1; step(); a_abort = 0;
    if (a_done) done_seen++;
    n_checks++; if (a_out !== 8'h00 || a_busy !== 1'b0 || a_idx !== 3'd4) begin n_fail++; $display("FAIL abort_out out=%h busy=%b idx=%0d want 00/0/4", a_out, a_busy, a_idx); end
    step();
    if (a_done) done_seen++;
    n_checks++; if (a_out !== 8'h01 || a_busy !== 1'b1 || a_idx !== 3'd0) begin n_fail++; $display("FAIL abort_restart out=%h busy=%b idx=%0d want 01/1/0", a_out, a_busy, a_idx); end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_nodone pulses=%0d want 0", done_seen); end
    a_start = 0; a_abort = 1; step();
    n_checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL abort2 busy=%b done=%b want 0/0", a_busy, a_done); end
    a_sel = 3'd2; step();
    n_checks++; if (a_out !== 8'h04 || a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ignored out=%h busy=%b want 04/0", a_out, a_busy); end
    a_abort = 0; a_en = 0; step();
  endtask

  task automatic test_start_priority();
    a_en = 1; a_sel = 3'd7; a_start = 1; step(); a_start = 0;
    n_checks++; if (a_out !== 8'h01 || a_busy !== 1'b1) begin n_fail++; $display("FAIL start_prio out=%h busy=%b want 01/1", a_out, a_busy); end
    for (int k = 0; k < 6; k++) step();
    n_checks++; if (a_out !== 8'h40 || a_idx !== 3'd6) begin n_fail++; $display("FAIL prio_idx6 out=%h idx=%0d want 40/6", a_out, a_idx); end
    #2 reset = 1'b1; #1;
    n_checks++; if ({a_out, a_idx, a_busy, a_done} !== 13'h0) begin n_fail++; $display("FAIL reset_midscan out=%h idx=%0d busy=%b done=%b want 0", a_out, a_idx, a_busy, a_done); end
    a_en = 1; a_sel = 3'd1; #1 reset = 1'b0;
    step();
    n_checks++; if (a_out !== 8'h02 || a_idx !== 3'd1 || a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle out=%h idx=%0d busy=%b done=%b want 02/1/0/0", a_out, a_idx, a_busy, a_done); end
    a_en = 0; step();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell1();
    test_dwell3_stall();
    test_abort();
    test_start_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
